// File: rtl/sti_lut_bank.sv
// Programmable bank of NUM_OUT single-bit truth tables (IN_W inputs each) behind a
// two-stage valid/ready pipeline. Optional output remasking: define STI_REMASK_EN.
module sti_lut_bank #(
   parameter int IN_W    = 8,
   parameter int NUM_OUT = 16,
   localparam int FN_W   = $clog2(NUM_OUT),
   localparam int AW     = FN_W + IN_W - 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [31:0]        cfg_wdata,
   input  logic               cfg_lock,
   output logic               cfg_err,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   input  logic [NUM_OUT-1:0] rnd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_data,
   output logic               running
);

   localparam int DEPTH  = 2 ** IN_W;
   localparam int STAGES = 2;

   typedef enum logic {S_CFG, S_RUN} state_t;

   state_t                            r_state, w_state_nxt;
   logic [NUM_OUT-1:0][DEPTH-1:0]     r_tab;
   logic                              r_err;
   logic [STAGES:1]                   r_vld_pipe;
   logic [IN_W-1:0]                   r_s1_x;
   logic [NUM_OUT-1:0]                r_out_data;
   logic [NUM_OUT-1:0]                w_raw, w_look;
   logic [FN_W-1:0]                   w_fn;
   logic [IN_W-1:0]                   w_base;
   logic                              w_fn_ok, w_wr, w_err_set, w_run;
   logic                              w_adv, w_xfer;

   assign w_fn    = cfg_addr[AW-1 -: FN_W];
   assign w_fn_ok = int'(w_fn) < NUM_OUT;

   // Word index selects a 32-bit slice; with IN_W==5 a table is a single word.
   generate
      if (IN_W > 5) begin : g_word
         assign w_base = {cfg_addr[IN_W-6:0], 5'd0};
      end else begin : g_noword
         assign w_base = '0;
      end
   endgenerate

   always_comb begin
      w_state_nxt = r_state;
      w_run       = 1'b0;
      w_wr        = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         S_CFG: begin
            w_wr      = cfg_we & w_fn_ok;
            w_err_set = cfg_we & ~w_fn_ok;
            if (cfg_lock) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_run     = 1'b1;
            w_err_set = cfg_we;
         end
         default: w_state_nxt = S_CFG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_CFG;
         r_err   <= 1'b0;
         r_tab   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_err_set) r_err <= 1'b1;
         if (w_wr)      r_tab[w_fn][w_base +: 32] <= cfg_wdata;
      end
   end

   // Both stages move together; a stalled output freezes S1 as well.
   assign w_adv  = ~r_vld_pipe[STAGES] | out_ready;
   assign w_xfer = in_valid & w_run & w_adv;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_lut
         assign w_raw[gi] = r_tab[gi][r_s1_x];
      end
   endgenerate

`ifdef STI_REMASK_EN
   logic [NUM_OUT-1:0] r_s1_rnd;

   always_ff @(posedge clk) begin
      if (rst)         r_s1_rnd <= '0;
      else if (w_xfer) r_s1_rnd <= rnd;
   end

   assign w_look = w_raw ^ r_s1_rnd;
`else
   logic w_unused_rnd;
   assign w_unused_rnd = ^rnd;
   assign w_look       = w_raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_s1_x     <= '0;
         r_out_data <= '0;
      end else begin
         if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_xfer};
         if (w_xfer) r_s1_x <= in_data;
         if (w_adv && r_vld_pipe[1]) r_out_data <= w_look;
      end
   end

   assign cfg_err   = r_err;
   assign running   = w_run;
   assign in_ready  = w_run & w_adv;
   assign out_valid = r_vld_pipe[STAGES];
   assign out_data  = r_out_data;

endmodule

// File: doc/sti_lut_bank.md
# sti_lut_bank

Programmable, pipelined bank of single-bit Boolean component functions for threshold-implementation (TI) S-box shares. It generalises the fixed 8-input share-bit tables to NUM_OUT run-time-loadable truth tables of IN_W inputs each. A valid/ready pipeline registers the function inputs and outputs so that every share bit is glitch-isolated. The block sits between share-generation and share-compression stages of a masked S-box datapath; tables are loaded once after reset and then locked.

## Interface
- IN_W, 8, inputs per component function (concatenated input shares); legal range 5..10
- NUM_OUT, 16, number of component functions (output share bits)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table word write strobe
- cfg_addr  in  $clog2(NUM_OUT)+IN_W-5  {function index, word index}
- cfg_wdata  in  32  truth-table word; bit b of word w is f(32*w+b)
- cfg_lock  in  1  pulse: leave CFG, enter RUN
- cfg_err  out  1  sticky: write attempted while in RUN, or function index >= NUM_OUT
- in_valid  in  1  input share vector valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  IN_W  function input x
- rnd  in  NUM_OUT  fresh mask bits, sampled together with in_data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  NUM_OUT  bit f = table_f(x) (XOR mask when enabled)
- running  out  1  high in RUN state

## Operation
- Storage: NUM_OUT x 2^IN_W bits, cleared to zero by rst.
- FSM states: CFG (reset state), RUN.
  - CFG: cfg_we writes cfg_wdata to table[fn][32*w +: 32]. Out-of-range fn: write dropped, cfg_err set. in_ready=0. cfg_lock -> RUN next cycle.
  - RUN: tables read-only; cfg_we sets cfg_err, write dropped. cfg_lock ignored. Only rst returns to CFG.
  - cfg_we and cfg_lock in the same CFG cycle: write performed, then RUN.
- Pipeline: S1 registers {in_data, rnd}; S2 registers lookup result. Lookup is combinational only between S1 and S2; no path from in_data to out_data without a register.
- Advance enable: adv = !out_valid | out_ready. Both stages move only when adv=1. in_ready = running & adv.
- A transfer occurs on in_valid & in_ready. S1 valid takes the handshake value when adv=1. S2 output follows S1 when adv=1.
- While stalled (adv=0), out_data, out_valid and S1 contents hold stable.
- rst mid-operation: both valids cleared, in-flight data discarded, tables cleared, state CFG, cfg_err cleared.

## Timing
- Reset values: cfg_err=0, in_ready=0, out_valid=0, out_data=0, running=0.
- running rises the cycle after the cfg_lock pulse; in_ready rises with it when adv=1.
- Latency: input accepted at edge N -> out_valid=1 with its result after edge N+1 (2-cycle latency). Throughput: 1 per cycle with out_ready held high.
- A table write at edge N is visible to lookups from edge N+1 (CFG only, so never races RUN traffic).
- cfg_err rises the cycle after the offending write and stays high until rst.

## Configuration
- STI_REMASK_EN defined: S2 captures table(x) XOR rnd as sampled in S1. rnd must be fresh per transfer.
- STI_REMASK_EN undefined: rnd is ignored, and S2 captures table(x) directly.

## Test plan
- Reset/idle: assert rst 2 cycles -> all outputs 0; in_valid=1 during CFG -> no out_valid ever.
- Single lookup: write fn3 word0 = 32'h0000_0004, lock, send x=2 -> out_data=16'h0008 two cycles after acceptance; x=3 -> 16'h0000.
- Backpressure: stream x=0..7 with out_ready toggling 1,0,0,1 -> every result delivered exactly once, in order; out_data stable while stalled.
- Lock protection: after lock, write fn0 word0 = 32'hFFFF_FFFF -> cfg_err=1 next cycle; x=0 still returns bit0=0.
- Remask (STI_REMASK_EN): all tables zero, x=5, rnd=16'hA5A5 -> out_data=16'hA5A5; without macro -> 16'h0000.
- Mid-stream reset: rst with both stages valid -> out_valid=0 next cycle, running=0, previously loaded table reads 0 after relock.
